// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and constants for the register-file sequencer: FSM states,
// op bit positions and the entry-state decode applied when a request is accepted.
package reg_file_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 5;
    localparam int DATA_W_DEFAULT = 16;

    localparam int OP_RD1 = 2;
    localparam int OP_RD2 = 1;
    localparam int OP_WR  = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        CAP  = 3'd3,
        WR1  = 3'd4,
        WR2  = 3'd5,
        RESP = 3'd6
    } state_e;

    // Reads are always sequenced before the write, so any read bit enters the read phase.
    function automatic state_e first_state(input logic [2:0] op);
        if (op[OP_RD1] || op[OP_RD2]) begin
            return RD1;
        end else if (op[OP_WR]) begin
            return WR1;
        end else begin
            return RESP;
        end
    endfunction

endpackage

// File: rtl/reg_file_ctrl_arb.sv
// Two-input round-robin arbiter. The last-grant pointer moves only when the
// grant is actually consumed, so an unaccepted grant does not steal a turn.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic last_q;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    // Reset to "requester 1 granted last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance_i && (grant_o != 2'b00)) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Two-requester sequencer in front of the 32x16 register file: arbitrates,
// drives the two-cycle input_valid phases (reads then write) and returns read data.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [2:0]        rq0_op,
    input  logic [ADDR_W-1:0] rq0_rs1,
    input  logic [ADDR_W-1:0] rq0_rs2,
    input  logic [ADDR_W-1:0] rq0_rd,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic [2:0]        rq1_op,
    input  logic [ADDR_W-1:0] rq1_rs1,
    input  logic [ADDR_W-1:0] rq1_rs2,
    input  logic [ADDR_W-1:0] rq1_rd,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    output logic              err,
    output logic [ADDR_W-1:0] rf_read1,
    output logic [ADDR_W-1:0] rf_read2,
    output logic [ADDR_W-1:0] rf_write,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [2:0]        rf_input_valid,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    input  logic              rf_output_valid
);

    state_e            state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic              id_q;
    logic [DATA_W-1:0] rdata1_q, rdata2_q;
    logic              err_q;

    logic              in_idle;
    logic [1:0]        grant;
    logic              accept;
    logic              sel_id;
    logic [2:0]        sel_op;
    logic [ADDR_W-1:0] sel_rs1, sel_rs2, sel_rd;
    logic [DATA_W-1:0] sel_wdata;
    logic              has_read;
    logic              capture;
    logic              wr_check;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && (rq0_valid || rq1_valid);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({rq1_valid, rq0_valid}),
        .advance_i (accept),
        .grant_o   (grant)
    );

    assign rq0_ready = in_idle && grant[0];
    assign rq1_ready = in_idle && grant[1];

    assign sel_id    = grant[1];
    assign sel_op    = sel_id ? rq1_op    : rq0_op;
    assign sel_rs1   = sel_id ? rq1_rs1   : rq0_rs1;
    assign sel_rs2   = sel_id ? rq1_rs2   : rq0_rs2;
    assign sel_rd    = sel_id ? rq1_rd    : rq0_rd;
    assign sel_wdata = sel_id ? rq1_wdata : rq0_wdata;

    // Read data is ready the cycle after the read phase: CAP, or WR1 when a write follows.
    assign has_read = op_q[OP_RD1] || op_q[OP_RD2];
    assign capture  = (state_q == CAP) || ((state_q == WR1) && has_read);
    assign wr_check = (state_q == RESP) && op_q[OP_WR];

    // Decoded from the state register alone so an async reset drops it at once.
    always_comb begin
        rf_input_valid = 3'b000;
        case (state_q)
            RD1, RD2: rf_input_valid = {op_q[OP_RD1], op_q[OP_RD2], 1'b0};
            WR1, WR2: rf_input_valid = 3'b001;
            default:  rf_input_valid = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            wdata_q  <= '0;
            id_q     <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= first_state(sel_op);
                        op_q     <= sel_op;
                        rs1_q    <= sel_rs1;
                        rs2_q    <= sel_rs2;
                        rd_q     <= sel_rd;
                        wdata_q  <= sel_wdata;
                        id_q     <= sel_id;
                        rdata1_q <= '0;
                        rdata2_q <= '0;
                    end
                end
                RD1:     state_q <= RD2;
                RD2:     state_q <= op_q[OP_WR] ? WR1 : CAP;
                CAP:     state_q <= RESP;
                WR1:     state_q <= WR2;
                WR2:     state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (capture) begin
                rdata1_q <= op_q[OP_RD1] ? rf_out1 : '0;
                rdata2_q <= op_q[OP_RD2] ? rf_out2 : '0;
                if (!rf_output_valid) begin
                    err_q <= 1'b1;
                end
            end
            if (wr_check && !rf_output_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = id_q;
    assign rsp_rdata1    = rdata1_q;
    assign rsp_rdata2    = rdata2_q;
    assign err           = err_q;
    assign rf_read1      = rs1_q;
    assign rf_read2      = rs2_q;
    assign rf_write      = rd_q;
    assign rf_write_data = wdata_q;

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Sequencer and two-port arbiter in front of the 32×16 register file. Accepts register-access operations from two requesters (e.g. issue slot and debug port), grants them round-robin, drives the register file's `input_valid` two-cycle handshake, and returns read data with a one-cycle response pulse. It is the only master of the register file; the register file's own read/write phasing is hidden from requesters.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 16, data width

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rq0_valid`, `rq1_valid` in 1: request present
- `rq0_ready`, `rq1_ready` out 1: request accepted this cycle
- `rq0_op`, `rq1_op` in 3: bit2 read port 1, bit1 read port 2, bit0 write (same encoding as register file `input_valid`)
- `rq0_rs1`/`rs2`/`rd`, `rq1_rs1`/`rs2`/`rd` in ADDR_W each: read/write addresses
- `rq0_wdata`, `rq1_wdata` in DATA_W: write data
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_id` out 1: requester that completed
- `rsp_rdata1`, `rsp_rdata2` out DATA_W: read data; zero for ports not requested
- `err` out 1: sticky protocol error
- `rf_read1`, `rf_read2`, `rf_write` out ADDR_W; `rf_write_data` out DATA_W; `rf_input_valid` out 3
- `rf_out1`, `rf_out2` in DATA_W; `rf_output_valid` in 1

## Operation
- States: IDLE, RD1, RD2, CAP, WR1, WR2, RESP.
- IDLE: round-robin pick among valid requesters; pointer favours the requester not granted last; reset pointer makes rq0 win the first tie. Winner's `ready`=1 combinationally, loser's 0; `ready`=0 in all other states.
- On accept, latch op, addresses, wdata, id. Next state: RD1 if op[2]|op[1], else WR1 if op[0], else RESP (op 000 = no-op, returns zeros).
- RD1, RD2: `rf_input_valid`={op[2],op[1],0}. RD2 → WR1 if op[0], else CAP.
- CAP, or WR1 following RD2: capture `rf_out1`/`rf_out2` into `rsp_rdata1`/`rsp_rdata2` (masked by op[2]/op[1]); `rf_output_valid` must be 1, else set `err`.
- WR1, WR2: `rf_input_valid`=3'b001. WR2 → RESP. In RESP after WR2, `rf_output_valid` must be 1, else set `err`.
- Reads always precede the write: a same-op read of `rd` returns the old value.
- RESP: `rsp_valid`=1 for one cycle, then IDLE. No response backpressure.
- `rf_*` address/data outputs held from latched request for the whole operation.

## Timing
- Reset values: state IDLE, `rf_input_valid`=0, `rsp_valid`=0, `rsp_rdata*`=0, `err`=0, `rq*_ready`=0, `rsp_id`=0, addresses/data 0.
- `rf_input_valid` decoded from the state register only; asserted for exactly two consecutive cycles per phase, never longer (register file's phase counter must end at 0).
- Latency, accept edge to `rsp_valid` cycle: op 000 → 1; write-only → 3; read-only → 4; read+write → 5.
- Throughput: one op per latency+1 cycles; next accept earliest in IDLE cycle after RESP.
- Async reset mid-operation: immediate return to IDLE, `rf_input_valid` drops at once. Register file has no reset, so its counter may be left at 1; the next phase then sees `rf_output_valid` in the wrong cycle and `err` sets. Clearing this is system reset sequencing, out of scope.
- `err` clears only on reset.

## Structure
- Package `reg_file_ctrl_pkg`: state enum, op bit-index constants (`OP_RD1`=2, `OP_RD2`=1, `OP_WR`=0), default `ADDR_W`/`DATA_W`.
- Sub-module `rr_arb2`: two-input round-robin arbiter with last-grant pointer, advanced on accept only.

## Test plan
- After reset, rq0 write r5=16'h1234 (op 001) → `rf_input_valid`=001 for 2 cycles, `rsp_valid` 3 cycles after accept, `rsp_id`=0, `err`=0.
- rq1 read r5,r0 (op 110) → `rf_input_valid`=110 for 2 cycles, `rsp_rdata1`=16'h1234, `rsp_rdata2`=0 at `rsp_valid`, 4 cycles after accept.
- rq0 op 101 rs1=r5, rd=r5, wdata=16'hBEEF → `rsp_rdata1`=16'h1234 at 5 cycles; following read of r5 returns 16'hBEEF.
- Both requesters valid continuously with op 000 → grants alternate rq0, rq1, rq0…; each `rsp_valid` 1 cycle after its accept.
- Model `rf_output_valid` stuck 0 → `err`=1 after the first phase, stays 1 until `rst_n` low.
- Assert `rst_n` low during RD2 → `rf_input_valid`=0 and state IDLE same cycle; new request accepted after release.
